jesd204b_tx_link_ctrl: RTL and testbench

Link-layer sequencer for the JESD204B transmitter. It drives the per-lane control characters for Code Group Synchronisation (CGS) and the Initial Lane Alignment Sequence (ILAS), then hands the lanes to the transport-layer data. It sits between the transport mapper and the 8b/10b encoder: when `data_sel` = 1 the encoder input takes mapper octets, otherwise it takes `ctrl_octets`/`ctrl_k`. The block also owns the LMFC counter and the SYNC~ handling, including resynchronisation.

---
 rtl/jesd204b_tx_link_ctrl_if.sv | 12 +
 rtl/jesd204b_tx_link_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_jesd204b_tx_link_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jesd204b_tx_link_ctrl_if.sv
// Encoder-side bus of the JESD204B TX link controller: mapper/control mux select
// plus the per-lane control octets and their K flags.
interface jesd204b_tx_link_ctrl_if #(
   parameter int LANES = 4
);
   logic                data_sel;
   logic [LANES*16-1:0] ctrl_octets;
   logic [LANES*2-1:0]  ctrl_k;

   modport master (output data_sel, output ctrl_octets, output ctrl_k);
   modport slave  (input  data_sel, input  ctrl_octets, input  ctrl_k);
endinterface

// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B TX link-layer sequencer: LMFC counter, SYNC~ handling with resync,
// and CGS / ILAS / DATA control-character generation for every lane.
module jesd204b_tx_link_ctrl #(
   parameter int LANES      = 4,
   parameter int K          = 32,
   parameter int ILAS_MF    = 4,
   parameter int RESYNC_LEN = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 link_en,
   input  logic                 sync_n,
   input  logic [111:0]         ilas_cfg,
   output logic [1:0]           tx_state,
   output logic [$clog2(K)-1:0] lmfc_cnt,
   output logic                 lmfc_pulse,
   output logic [7:0]           sync_err_cnt,
   jesd204b_tx_link_ctrl_if.master enc
);
   localparam int LMFC_W = $clog2(K);
   localparam int POS_W  = LMFC_W + 1;
   localparam int MF_W   = $clog2(ILAS_MF + 1);
   localparam int RC_W   = $clog2(RESYNC_LEN + 1);

   localparam logic [LMFC_W-1:0] LMFC_LAST = LMFC_W'(K - 1);
   localparam logic [MF_W-1:0]   MF_LAST   = MF_W'(ILAS_MF - 1);
   localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RESYNC_LEN - 1);
   localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(2 * K - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CGS  = 2'd1,
      ST_ILAS = 2'd2,
      ST_DATA = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LMFC_W-1:0]   lmfc_q, lmfc_d;
   logic                pulse_q, pulse_d;
   logic [MF_W-1:0]     mf_q, mf_d;
   logic [RC_W-1:0]     low_cnt_q, low_cnt_d;
   logic [7:0]          err_q, err_d;
   logic                sync_meta_q, sync_meta_d;
   logic                sync_s_q, sync_s_d;
   logic                data_sel_q, data_sel_d;
   logic [LANES*16-1:0] octets_q, octets_d;
   logic [LANES*2-1:0]  k_q, k_d;
   logic                resync;
   logic [8:0]          sym;

   // Config octet n as seen by a given lane: octet 1 carries the LID in its low bits.
   function automatic logic [7:0] sub_octet(input logic [111:0] cfg, input int lane, input int n);
      if (n == 1) return {cfg[15:13], 5'(lane)};
      return cfg[8*n +: 8];
   endfunction

   function automatic logic [7:0] cfg_octet(input logic [111:0] cfg, input int lane, input int n);
      logic [7:0] sum;
      if (n != 13) return sub_octet(cfg, lane, n);
      sum = 8'h00;
      for (int j = 0; j < 13; j++) sum = sum + sub_octet(cfg, lane, j);
      return sum;
   endfunction

   // Returns {k, octet} for octet position p of multiframe mf of the ILAS.
   function automatic logic [8:0] ilas_sym(input logic [111:0] cfg, input int lane,
                                           input logic [MF_W-1:0] mf, input logic [POS_W-1:0] p);
      logic [15:0] pw;
      pw = 16'(p);
      if (p == '0) return {1'b1, 8'h1C};
      if (p == POS_LAST) return {1'b1, 8'h7C};
      if (mf == MF_W'(1) && p == POS_W'(1)) return {1'b1, 8'h9C};
      if (mf == MF_W'(1) && p >= POS_W'(2) && p <= POS_W'(15))
         return {1'b0, cfg_octet(cfg, lane, int'(p) - 2)};
      return {1'b0, pw[7:0]};
   endfunction

   always_comb begin
      sync_meta_d = sync_n;
      sync_s_d    = sync_meta_q;
      lmfc_d      = (lmfc_q == LMFC_LAST) ? '0 : lmfc_q + LMFC_W'(1);
      state_d     = state_q;
      mf_d        = mf_q;
      low_cnt_d   = low_cnt_q;
      err_d       = err_q;
      resync      = 1'b0;

      if (!link_en) begin
         state_d   = ST_IDLE;
         mf_d      = '0;
         low_cnt_d = '0;
      end else begin
         // A low run shorter than RESYNC_LEN is only an error once SYNC~ returns high.
         if (state_q == ST_ILAS || state_q == ST_DATA) begin
            if (!sync_s_q) begin
               if (low_cnt_q == RC_LAST) begin
                  resync    = 1'b1;
                  low_cnt_d = '0;
               end else begin
                  low_cnt_d = low_cnt_q + RC_W'(1);
               end
            end else if (low_cnt_q != '0) begin
               low_cnt_d = '0;
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
         end

         if (resync) begin
            state_d = ST_CGS;
            mf_d    = '0;
         end else begin
            case (state_q)
               ST_IDLE: state_d = ST_CGS;
               ST_CGS: begin
                  if (sync_s_q && lmfc_q == LMFC_LAST) begin
                     state_d = ST_ILAS;
                     mf_d    = '0;
                  end
               end
               ST_ILAS: begin
                  if (lmfc_q == LMFC_LAST) begin
                     if (mf_q == MF_LAST) begin
                        state_d = ST_DATA;
                        mf_d    = '0;
                     end else begin
                        mf_d = mf_q + MF_W'(1);
                     end
                  end
               end
               default: state_d = state_q;
            endcase
         end
      end

      pulse_d    = (lmfc_d == '0);
      data_sel_d = (state_d == ST_DATA);
      octets_d   = '0;
      k_d        = '0;
      sym        = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int i = 0; i < 2; i++) begin
            if (state_d == ST_CGS) begin
               octets_d[(2*l+i)*8 +: 8] = 8'hBC;
               k_d[2*l+i]               = 1'b1;
            end else if (state_d == ST_ILAS) begin
               sym                      = ilas_sym(ilas_cfg, l, mf_d, {lmfc_d, 1'(i)});
               octets_d[(2*l+i)*8 +: 8] = sym[7:0];
               k_d[2*l+i]               = sym[8];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         lmfc_q      <= '0;
         pulse_q     <= 1'b1;
         mf_q        <= '0;
         low_cnt_q   <= '0;
         err_q       <= 8'h00;
         sync_meta_q <= 1'b0;
         sync_s_q    <= 1'b0;
         data_sel_q  <= 1'b0;
         octets_q    <= '0;
         k_q         <= '0;
      end else begin
         state_q     <= state_d;
         lmfc_q      <= lmfc_d;
         pulse_q     <= pulse_d;
         mf_q        <= mf_d;
         low_cnt_q   <= low_cnt_d;
         err_q       <= err_d;
         sync_meta_q <= sync_meta_d;
         sync_s_q    <= sync_s_d;
         data_sel_q  <= data_sel_d;
         octets_q    <= octets_d;
         k_q         <= k_d;
      end
   end

   assign tx_state        = state_q;
   assign lmfc_cnt        = lmfc_q;
   assign lmfc_pulse      = pulse_q;
   assign sync_err_cnt    = err_q;
   assign enc.data_sel    = data_sel_q;
   assign enc.ctrl_octets = octets_q;
   assign enc.ctrl_k      = k_q;
endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Self-checking bench for jesd204b_tx_link_ctrl: a per-cycle reference model feeds
// a scoreboard queue, plus directed checks of the bring-up, ILAS content and resync.
module tb_jesd204b_tx_link_ctrl;
   localparam int LANES      = 4;
   localparam int K          = 32;
   localparam int ILAS_MF    = 4;
   localparam int RESYNC_LEN = 4;
   localparam int LW         = $clog2(K);

   logic          clock = 1'b0;
   logic          reset;
   logic          link_en;
   logic          sync_n;
   logic [111:0]  ilas_cfg;
   logic [1:0]    tx_state;
   logic [LW-1:0] lmfc_cnt;
   logic          lmfc_pulse;
   logic [7:0]    sync_err_cnt;

   jesd204b_tx_link_ctrl_if #(.LANES(LANES)) enc ();

   jesd204b_tx_link_ctrl #(
      .LANES(LANES), .K(K), .ILAS_MF(ILAS_MF), .RESYNC_LEN(RESYNC_LEN)
   ) dut (
      .clock(clock), .reset(reset), .link_en(link_en), .sync_n(sync_n),
      .ilas_cfg(ilas_cfg), .tx_state(tx_state), .lmfc_cnt(lmfc_cnt),
      .lmfc_pulse(lmfc_pulse), .sync_err_cnt(sync_err_cnt), .enc(enc)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [1:0]          state;
      logic                data_sel;
      logic [LANES*16-1:0] oct;
      logic [LANES*2-1:0]  k;
      logic [LW-1:0]       lmfc;
      logic                pulse;
      logic [7:0]          err;
   } exp_t;

   exp_t exp_q[$];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ILAS symbol straight from the lane-alignment rules, with plain integer arithmetic.
   function automatic void ref_ilas(input logic [111:0] cfg, input int lane, input int m, input int p,
                                    output logic [7:0] oct, output logic k);
      logic [7:0] o[14];
      int sum;
      for (int n = 0; n < 14; n++) o[n] = cfg[8*n +: 8];
      o[1] = (o[1] & 8'hE0) | 8'(lane % 32);
      sum = 0;
      for (int n = 0; n < 13; n++) sum += int'(o[n]);
      o[13] = 8'(sum % 256);
      k = 1'b0;
      if (p == 0) begin oct = 8'h1C; k = 1'b1; end
      else if (p == 2*K - 1) begin oct = 8'h7C; k = 1'b1; end
      else if (m == 1 && p == 1) begin oct = 8'h9C; k = 1'b1; end
      else if (m == 1 && p >= 2 && p <= 15) oct = o[p-2];
      else oct = 8'(p % 256);
   endfunction

   // Reference model: link mode as 0..3, ILAS progress as cycles elapsed since it began.
   int m_mode, m_cyc, m_low, m_err, m_ilas_t;
   bit pin_hist[$];

   always @(posedge clock) begin
      exp_t e;
      bit s_int;
      bit resync;
      logic [7:0] o;
      logic kk;
      if (!reset) begin
         m_mode = 0; m_cyc = 0; m_low = 0; m_err = 0; m_ilas_t = 0;
         pin_hist = {};
         pin_hist.push_back(1'b0);
         pin_hist.push_back(1'b0);
      end else begin
         s_int = pin_hist.pop_front();
         pin_hist.push_back(sync_n);
         if (!link_en) begin
            m_mode = 0;
            m_low  = 0;
         end else begin
            resync = 1'b0;
            if (m_mode == 2 || m_mode == 3) begin
               if (!s_int) begin
                  m_low++;
                  if (m_low == RESYNC_LEN) begin resync = 1'b1; m_low = 0; end
               end else begin
                  if (m_low > 0 && m_err < 255) m_err++;
                  m_low = 0;
               end
            end
            if (resync) m_mode = 1;
            else if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1) begin
               if (s_int && (m_cyc % K) == K - 1) begin m_mode = 2; m_ilas_t = 0; end
            end else if (m_mode == 2) begin
               m_ilas_t++;
               if (m_ilas_t == ILAS_MF * K) m_mode = 3;
            end
         end
         m_cyc++;
      end
      e.state    = 2'(m_mode);
      e.data_sel = (m_mode == 3);
      e.oct      = '0;
      e.k        = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int i = 0; i < 2; i++) begin
            if (m_mode == 1) begin
               e.oct[(2*l+i)*8 +: 8] = 8'hBC;
               e.k[2*l+i]            = 1'b1;
            end else if (m_mode == 2) begin
               ref_ilas(ilas_cfg, l, m_ilas_t / K, 2 * (m_ilas_t % K) + i, o, kk);
               e.oct[(2*l+i)*8 +: 8] = o;
               e.k[2*l+i]            = kk;
            end
         end
      end
      e.lmfc  = LW'(m_cyc % K);
      e.pulse = ((m_cyc % K) == 0);
      e.err   = 8'(m_err);
      exp_q.push_back(e);
   end

   // Monitor: the DUT presents new outputs every edge, compared 1 time unit later.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL scoreboard: no expectation queued at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         checkOutput("sb_tx_state",     64'(tx_state),        64'(e.state));
         checkOutput("sb_data_sel",     64'(enc.data_sel),    64'(e.data_sel));
         checkOutput("sb_ctrl_octets",  64'(enc.ctrl_octets), 64'(e.oct));
         checkOutput("sb_ctrl_k",       64'(enc.ctrl_k),      64'(e.k));
         checkOutput("sb_lmfc_cnt",     64'(lmfc_cnt),        64'(e.lmfc));
         checkOutput("sb_lmfc_pulse",   64'(lmfc_pulse),      64'(e.pulse));
         checkOutput("sb_sync_err_cnt", 64'(sync_err_cnt),    64'(e.err));
      end
   end

   function automatic logic [8:0] lane_sym(input int l, input int i);
      return {enc.ctrl_k[2*l+i], enc.ctrl_octets[(2*l+i)*8 +: 8]};
   endfunction

   task automatic wait_state(input logic [1:0] target, input int budget);
      int n;
      n = 0;
      while (tx_state !== target && n < budget) begin
         @(negedge clock);
         n++;
      end
      checkOutput("wait_state", 64'(tx_state), 64'(target));
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_tx_state"},    64'(tx_state),        64'd0);
      checkOutput({tag, "_data_sel"},    64'(enc.data_sel),    64'd0);
      checkOutput({tag, "_octets"},      64'(enc.ctrl_octets), 64'd0);
      checkOutput({tag, "_k"},           64'(enc.ctrl_k),      64'd0);
      checkOutput({tag, "_lmfc_cnt"},    64'(lmfc_cnt),        64'd0);
      checkOutput({tag, "_lmfc_pulse"},  64'(lmfc_pulse),      64'd1);
      checkOutput({tag, "_sync_err"},    64'(sync_err_cnt),    64'd0);
   endtask

   task automatic applyStimulus();
      logic [127:0] rnd;
      int left, len;

      // Bring-up with config octets 0x01..0x0E.
      reset = 1'b0; link_en = 1'b0; sync_n = 1'b0;
      for (int n = 0; n < 14; n++) ilas_cfg[8*n +: 8] = 8'(n + 1);
      repeat (5) @(negedge clock);
      check_reset_values("reset");
      reset = 1'b1; link_en = 1'b1;
      repeat (100) @(negedge clock);
      checkOutput("cgs_state",  64'(tx_state),        64'd1);
      checkOutput("cgs_octets", 64'(enc.ctrl_octets), {8{8'hBC}});
      checkOutput("cgs_k",      64'(enc.ctrl_k),      64'hFF);
      sync_n = 1'b1;
      wait_state(2'd2, 3 * K);
      checkOutput("ilas_start_lmfc", 64'(lmfc_cnt), 64'd0);
      for (int t = 0; t < ILAS_MF * K; t++) begin
         case (t)
            0:           checkOutput("ilas_l2_p0",     64'(lane_sym(2, 0)), 64'h11C);
            10:          checkOutput("ilas_l2_p20",    64'(lane_sym(2, 0)), 64'h014);
            K - 1:       checkOutput("ilas_l2_p63",    64'(lane_sym(2, 1)), 64'h17C);
            K:           checkOutput("ilas_l2_m1_q",   64'(lane_sym(2, 1)), 64'h19C);
            K + 1:       checkOutput("ilas_l2_lid",    64'(lane_sym(2, 1)), 64'h002);
            K + 7:       checkOutput("ilas_l2_fchk",   64'(lane_sym(2, 1)), 64'h05B);
            ILAS_MF*K-1: checkOutput("ilas_last_state", 64'(tx_state),      64'd2);
            default: ;
         endcase
         @(negedge clock);
      end
      checkOutput("data_state",    64'(tx_state),     64'd3);
      checkOutput("data_data_sel", 64'(enc.data_sel), 64'd1);

      // Short SYNC~ pulses in DATA: counted as errors, saturating.
      sync_n = 1'b0;
      repeat (3) @(negedge clock);
      sync_n = 1'b1;
      repeat (5) @(negedge clock);
      checkOutput("short_sync_err1",   64'(sync_err_cnt), 64'd1);
      checkOutput("short_sync_state1", 64'(tx_state),     64'd3);
      for (int n = 0; n < 299; n++) begin
         sync_n = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clock);
         sync_n = 1'b1;
         repeat ($urandom_range(3, 6)) @(negedge clock);
      end
      checkOutput("short_sync_sat",   64'(sync_err_cnt), 64'd255);
      checkOutput("short_sync_state", 64'(tx_state),     64'd3);

      // Resync: four synchronised low clocks force CGS six clocks after the pin falls.
      sync_n = 1'b0;
      repeat (4) @(negedge clock);
      sync_n = 1'b1;
      @(negedge clock);
      checkOutput("resync_still_data", 64'(tx_state), 64'd3);
      @(negedge clock);
      checkOutput("resync_cgs", 64'(tx_state), 64'd1);
      wait_state(2'd2, 3 * K);
      checkOutput("resync_ilas_lmfc", 64'(lmfc_cnt), 64'd0);

      // Disable at lmfc 10 of multiframe 2.
      repeat (2 * K + 10) @(negedge clock);
      checkOutput("dis_lmfc_before", 64'(lmfc_cnt), 64'd10);
      link_en = 1'b0;
      @(negedge clock);
      checkOutput("dis_state",    64'(tx_state),        64'd0);
      checkOutput("dis_octets",   64'(enc.ctrl_octets), 64'd0);
      checkOutput("dis_k",        64'(enc.ctrl_k),      64'd0);
      checkOutput("dis_data_sel", 64'(enc.data_sel),    64'd0);
      checkOutput("dis_lmfc",     64'(lmfc_cnt),        64'd11);

      // Asynchronous reset mid-DATA.
      link_en = 1'b1;
      wait_state(2'd3, 8 * K);
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check_reset_values("async_reset");
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Randomised phase: random config, SYNC~ glitches of 1..6 clocks, link drops.
      for (int r = 0; r < 15; r++) begin
         link_en = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clock);
         rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
         ilas_cfg = rnd[111:0];
         link_en = 1'b1;
         sync_n = 1'b0;
         repeat ($urandom_range(1, 60)) @(negedge clock);
         sync_n = 1'b1;
         left = $urandom_range(150, 400);
         while (left > 0) begin
            if ($urandom_range(0, 39) == 0) begin
               len = $urandom_range(1, 6);
               sync_n = 1'b0;
               repeat (len) @(negedge clock);
               sync_n = 1'b1;
               left -= len;
            end else if ($urandom_range(0, 299) == 0) begin
               link_en = 1'b0;
               @(negedge clock);
               link_en = 1'b1;
               left--;
            end else begin
               @(negedge clock);
               left--;
            end
         end
      end
      repeat (3) @(negedge clock);
   endtask

   initial begin
      applyStimulus();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
